// File: rtl/note_player.sv
`default_nettype none
// ============================================================================
//  Module   : note_player
//  Purpose  : Consumer end of the note handshake. Latches a note code and a
//             duration on new_note_i, produces a square-wave tone for that
//             many beat ticks, then pulses note_done_o for one cycle.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i        system clock, rising edge
//    reset_ni     asynchronous active-low reset
//    play_i       1 = run, 0 = pause (beats ignored, tone frozen and muted)
//    note_i       note code: 0 = rest, 1..63 = semitones up from A1 (55 Hz)
//    duration_i   note length in beat ticks (0 = zero-length note)
//    new_note_i   one-cycle strobe qualifying note_i / duration_i
//    beat_i       one-cycle beat tick
//    note_done_o  one-cycle pulse when the current note finishes
//    tone_out_o   square-wave audio output
//    busy_o       high while a note is loaded and not finished
// ============================================================================
module note_player #(
  parameter int CLK_HZ = 100000000,
  parameter int HP_W   = 20
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       play_i,
  input  logic [5:0] note_i,
  input  logic [5:0] duration_i,
  input  logic       new_note_i,
  input  logic       beat_i,
  output logic       note_done_o,
  output logic       tone_out_o,
  output logic       busy_o
);

  typedef logic [HP_W-1:0] hp_t;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_PLAY = 1'b1
  } state_e;

  // 2^(s/12) scaled by 1e9, so the table is built with integer math only.
  function automatic longint unsigned ratio_e9(input int s);
    case (s)
      0:       return 64'd1000000000;
      1:       return 64'd1059463094;
      2:       return 64'd1122462048;
      3:       return 64'd1189207115;
      4:       return 64'd1259921050;
      5:       return 64'd1334839854;
      6:       return 64'd1414213562;
      7:       return 64'd1498307077;
      8:       return 64'd1587401052;
      9:       return 64'd1681792831;
      10:      return 64'd1781797436;
      default: return 64'd1887748625;
    endcase
  endfunction

  // round(CLK_HZ / (110 * 2^(s/12))) computed as (2a + b) / (2b).
  function automatic hp_t semi_hp(input int s);
    longint unsigned a2;
    longint unsigned b;
    a2 = longint'(CLK_HZ) * 64'd2000000000;
    b  = 64'd110 * ratio_e9(s);
    return hp_t'((a2 + b) / (64'd2 * b));
  endfunction

  localparam hp_t SEMI_HP [12] = '{
    semi_hp(0), semi_hp(1), semi_hp(2),  semi_hp(3),
    semi_hp(4), semi_hp(5), semi_hp(6),  semi_hp(7),
    semi_hp(8), semi_hp(9), semi_hp(10), semi_hp(11)
  };

  localparam hp_t HP_MIN = hp_t'(2);

  state_e     state_q, state_d;
  logic [5:0] note_q, note_d;
  logic [5:0] beats_q, beats_d;
  hp_t        cnt_q, cnt_d;
  logic       tone_q, tone_d;
  logic       done_q, done_d;
  // A zero-length note arriving in a note_done cycle has its pulse deferred
  // by one cycle so note_done is never high on two consecutive cycles.
  logic       pend_q, pend_d;

  logic [5:0] w_note_m1;
  logic [3:0] w_semi;
  logic [2:0] w_oct;
  hp_t        w_hp_shift;
  hp_t        w_hp;
  logic       w_tone_run;

  assign w_note_m1  = note_q - 6'd1;
  assign w_semi     = 4'(w_note_m1 % 6'd12);
  assign w_oct      = 3'(w_note_m1 / 6'd12);
  assign w_hp_shift = SEMI_HP[w_semi] >> w_oct;
  assign w_hp       = (w_hp_shift < HP_MIN) ? HP_MIN : w_hp_shift;
  assign w_tone_run = play_i && (note_q != 6'd0);

  always_comb begin
    state_d = state_q;
    note_d  = note_q;
    beats_d = beats_q;
    cnt_d   = cnt_q;
    tone_d  = tone_q;
    done_d  = 1'b0;
    pend_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        tone_d = 1'b0;
        if (pend_q) begin
          done_d = 1'b1;
        end else if (new_note_i) begin
          note_d  = note_i;
          beats_d = duration_i;
          if (duration_i == 6'd0) begin
            if (done_q) begin
              pend_d = 1'b1;
            end else begin
              done_d = 1'b1;
            end
          end else begin
            state_d = S_PLAY;
          end
        end
      end

      S_PLAY: begin
        if (w_tone_run) begin
          if (cnt_q >= w_hp - hp_t'(1)) begin
            cnt_d  = '0;
            tone_d = ~tone_q;
          end else begin
            cnt_d = cnt_q + hp_t'(1);
          end
        end
        // Beat handling is last so the end of a note overrides the tone update.
        if (play_i && beat_i) begin
          if (beats_q <= 6'd1) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            cnt_d   = '0;
            tone_d  = 1'b0;
          end else begin
            beats_d = beats_q - 6'd1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      note_q  <= '0;
      beats_q <= '0;
      cnt_q   <= '0;
      tone_q  <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      beats_q <= beats_d;
      cnt_q   <= cnt_d;
      tone_q  <= tone_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
    end
  end

  assign note_done_o = done_q;
  assign busy_o      = (state_q == S_PLAY);
  // Pause mutes the output while the internal phase is held.
  assign tone_out_o  = tone_q && play_i && (state_q == S_PLAY);

endmodule
`default_nettype wire

// File: tb/tb_note_player.sv
`default_nettype none
// ============================================================================
//  Module   : tb_note_player
//  Purpose  : Self-checking bench for note_player. Expected outputs come from
//             a reference model expressed as beat counting and elapsed-cycle
//             arithmetic on the tone half-period.
//  Revision : 1.0  initial release
// ============================================================================
module tb_note_player;

  localparam int CLK_HZ = 112640;   // makes the A1 half period exactly 1024
  localparam int HP_W   = 20;
  localparam int LIMIT  = 20000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       play;
  logic [5:0] note;
  logic [5:0] duration;
  logic       new_note;
  logic       beat;
  logic       note_done;
  logic       tone_out;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  note_player #(
    .CLK_HZ (CLK_HZ),
    .HP_W   (HP_W)
  ) dut (
    .clk_i       (clk),
    .reset_ni    (reset_n),
    .play_i      (play),
    .note_i      (note),
    .duration_i  (duration),
    .new_note_i  (new_note),
    .beat_i      (beat),
    .note_done_o (note_done),
    .tone_out_o  (tone_out),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  // Toggle interval in clk cycles for a note code, straight from the pitch
  // formula: 110 Hz reference scaled by the semitone ratio, octaves halve it.
  function automatic int exp_hp(input int nt);
    int  n;
    int  s;
    int  o;
    int  base;
    int  hp;
    real r;
    if (nt == 0) return 2;
    n    = nt - 1;
    s    = n % 12;
    o    = n / 12;
    r    = real'(CLK_HZ) / (110.0 * (2.0 ** (real'(s) / 12.0)));
    base = $rtoi(r + 0.5);
    hp   = base >> o;
    if (hp < 2) hp = 2;
    return hp;
  endfunction

  // Plays one note starting in the current cycle (which may be a note_done
  // cycle, for back-to-back use). Returns in the cycle where note_done is
  // expected, after checking it.
  task automatic run_note(input int nt, input int dur, input int per,
                          input bit beat0, input int ps, input int pe,
                          input bit junk);
    int hp;
    int counted;
    int act;
    int d_cyc;
    bit ended;
    bit e_done;
    bit e_busy;
    bit e_tone;
    hp      = exp_hp(nt);
    counted = 0;
    act     = 0;
    ended   = 1'b0;
    d_cyc   = (dur == 0) ? 1 : -1;
    new_note = 1'b1;
    note     = 6'(nt);
    duration = 6'(dur);
    beat     = beat0;
    play     = 1'b1;
    for (int c = 1; c <= LIMIT; c++) begin
      @(posedge clk); #1;
      new_note = 1'b0;
      beat     = (c % per == 0);
      play     = !(c >= ps && c < pe);
      if (junk && c != d_cyc && (c % 37 == 5)) begin
        new_note = 1'b1;
        note     = 6'd5;
        duration = 6'($urandom_range(1, 63));
      end
      #1;
      e_done = (c == d_cyc);
      e_busy = (d_cyc < 0);
      e_tone = e_busy && play && (nt != 0) && (((act / hp) % 2) == 1);
      n_cmp++;
      if (note_done !== e_done) begin
        n_bad++;
        $display("FAIL note_done note=%0d cyc=%0d got=%b exp=%b", nt, c, note_done, e_done);
      end
      n_cmp++;
      if (busy !== e_busy) begin
        n_bad++;
        $display("FAIL busy note=%0d cyc=%0d got=%b exp=%b", nt, c, busy, e_busy);
      end
      n_cmp++;
      if (tone_out !== e_tone) begin
        n_bad++;
        $display("FAIL tone_out note=%0d cyc=%0d got=%b exp=%b", nt, c, tone_out, e_tone);
      end
      if (c == d_cyc) begin
        ended = 1'b1;
        break;
      end
      if (play) act++;
      if (play && beat) begin
        counted++;
        if (counted == dur) d_cyc = c + 1;
      end
    end
    n_cmp++;
    if (!ended) begin
      n_bad++;
      $display("FAIL note_timeout note=%0d got=running exp=finished", nt);
    end
    new_note = 1'b0;
    beat     = 1'b0;
  endtask

  // Idle cycles with random beat/play: nothing may start or sound.
  task automatic idle_check(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      new_note = 1'b0;
      beat     = 1'($urandom_range(0, 1));
      play     = 1'($urandom_range(0, 1));
      #1;
      n_cmp++;
      if ({note_done, busy, tone_out} !== 3'b000) begin
        n_bad++;
        $display("FAIL idle cyc=%0d got=%b%b%b exp=000", c, note_done, busy, tone_out);
      end
    end
    beat = 1'b0;
    play = 1'b1;
  endtask

  task automatic test_reset();
    int act;
    reset_n  = 1'b0;
    play     = 1'b1;
    note     = '0;
    duration = '0;
    new_note = 1'b0;
    beat     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({note_done, busy, tone_out} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_state got=%b%b%b exp=000", note_done, busy, tone_out);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #2;
    // Load A1 for 4 beats, beats every 700 cycles, reset after 2 beats.
    new_note = 1'b1;
    note     = 6'd1;
    duration = 6'd4;
    act      = 0;
    for (int c = 1; c <= 1700; c++) begin
      @(posedge clk); #1;
      new_note = 1'b0;
      beat     = (c % 700 == 0);
      #1;
      if (c < 1700) act++;
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_busy got=%b exp=1", busy);
    end
    n_cmp++;
    if (tone_out !== 1'(((act / 1024) % 2) == 1)) begin
      n_bad++;
      $display("FAIL pre_reset_tone got=%b exp=%b", tone_out, ((act / 1024) % 2) == 1);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({note_done, busy, tone_out} !== 3'b000) begin
      n_bad++;
      $display("FAIL mid_note_reset got=%b%b%b exp=000", note_done, busy, tone_out);
    end
    beat = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #2;
    for (int c = 1; c <= 3000; c++) begin
      @(posedge clk); #1;
      beat = (c % 700 == 0);
      #1;
      n_cmp++;
      if ({note_done, busy, tone_out} !== 3'b000) begin
        n_bad++;
        $display("FAIL after_reset cyc=%0d got=%b%b%b exp=000", c, note_done, busy, tone_out);
      end
    end
    beat = 1'b0;
  endtask

  task automatic test_basic();
    run_note(1, 3, 2000, 1'b0, 0, 0, 1'b0);
    idle_check(5);
  endtask

  task automatic test_octave_rest();
    run_note(13, 2, 1500, 1'b0, 0, 0, 1'b0);
    idle_check(3);
    run_note(25, 2, 700, 1'b0, 0, 0, 1'b0);
    idle_check(3);
    run_note(0, 2, 500, 1'b0, 0, 0, 1'b0);
    idle_check(3);
  endtask

  task automatic test_pause();
    // Beat at 600 counts; 1200/1800/2400 fall inside the pause.
    run_note(1, 4, 600, 1'b0, 700, 2500, 1'b0);
    idle_check(3);
  endtask

  task automatic test_back_to_back();
    run_note(1, 2, 400, 1'b0, 0, 0, 1'b0);
    run_note(13, 2, 300, 1'b1, 0, 0, 1'b0);
    run_note(37, 1, 250, 1'b1, 0, 0, 1'b0);
    idle_check(2);
    run_note(7, 0, 100, 1'b0, 0, 0, 1'b0);
    idle_check(4);
  endtask

  task automatic test_ignore_during_play();
    run_note(1, 3, 900, 1'b0, 0, 0, 1'b1);
    idle_check(3);
  endtask

  task automatic test_random();
    int  nt;
    int  dur;
    int  per;
    int  ps;
    int  pe;
    bit  chain;
    for (int i = 0; i < 15; i++) begin
      nt    = $urandom_range(0, 63);
      dur   = $urandom_range(0, 4);
      per   = $urandom_range(50, 300);
      chain = 1'($urandom_range(0, 1));
      ps    = 0;
      pe    = 0;
      if ($urandom_range(0, 1) == 1) begin
        ps = $urandom_range(1, 2 * per);
        pe = ps + $urandom_range(1, 2 * per);
      end
      if (chain && dur == 0) dur = 1;
      if (!chain) idle_check(2);
      run_note(nt, dur, per, 1'($urandom_range(0, 1)), ps, pe,
               1'($urandom_range(0, 1)));
    end
    idle_check(3);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_octave_rest();
    test_pause();
    test_back_to_back();
    test_ignore_during_play();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/note_player.md
Name: note_player

Overview:
- Consumer end of the note handshake driven by song_reader.
- Accepts one note code and duration per new_note pulse.
- Generates a square-wave tone for that many beat ticks, then pulses note_done so song_reader can issue the next note.
- Sits between song_reader and the audio output stage; beat ticks come from a shared beat generator.

Parameters:
CLK_HZ, 100000000, clk frequency in Hz; used to precompute the half-period table.
HP_W, 20, width of the tone half-period counter; must hold round(CLK_HZ/110).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
play  input  1  1 = run, 0 = pause (freezes beat counting and tone, tone_out forced 0)
note  input  6  note code; 0 = rest, 1..63 = semitones upward from A1 (55 Hz)
duration  input  6  note length in beat ticks
new_note  input  1  one-cycle strobe: note/duration valid
beat  input  1  one-cycle beat tick
note_done  output  1  one-cycle pulse when the current note's duration expires
tone_out  output  1  square-wave audio output
busy  output  1  1 while a note is loaded and not finished

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, note_done=0, tone_out=0, busy=0.
  - Beat and tone counters cleared.
  - Applies mid-note: the current note is abandoned and no note_done is issued.
- States: IDLE, PLAY.
- IDLE:
  - busy=0, tone_out=0.
  - new_note=1 latches note and duration at that edge.
  - If duration!=0: next state PLAY, beats_left=duration, tone counter=0, tone_out=0.
  - If duration==0: stay IDLE and assert note_done for exactly the next cycle. This is a zero-length note.
- PLAY:
  - busy=1.
  - new_note is ignored; the latched note/duration are not changed.
  - If play=1 and beat=1, beats_left decrements.
  - When beats_left decrements from 1 to 0: next cycle state=IDLE, note_done=1 for that one cycle, tone_out=0.
  - If play=0: beat ticks are ignored, the tone counter holds, tone_out=0. On play=1 the tone resumes from the held count.
- Back-to-back notes:
  - The cycle where note_done=1 is an IDLE cycle.
  - A new_note in that same cycle is accepted, so there is no gap beat.
- note_done is registered and never high two cycles in a row.
- Tone generation (PLAY, play=1, note!=0):
  - n=note-1, oct=n/12, semi=n%12 (combinational, 6-bit).
  - HP = SEMI_HP[semi] >> oct, where SEMI_HP[s] = round(CLK_HZ / (110 * 2^(s/12))) is a 12-entry constant table computed at elaboration.
  - The HP_W-bit counter counts clk cycles. At count==HP-1 it toggles tone_out and the counter wraps to 0.
  - If HP<2 (after the shift), clamp HP to 2.
- Rest (note==0): tone_out stays 0 and beats still count normally.
- A beat tick in the same cycle as the new_note that loads a note is not counted.

Test Plan:
- Reset mid-note:
  - Stimulus: CLK_HZ=112640 (SEMI_HP[0]=1024); load note=1 duration=4; pull reset low after 2 beats.
  - Response: note_done, busy, and tone_out go 0 immediately. After release, state is IDLE and no note_done appears.
- Basic note:
  - Stimulus: CLK_HZ=112640, play=1, new_note with note=1 duration=3, beat every 2000 cycles.
  - Response:
    - tone_out toggles every 1024 cycles.
    - note_done pulses 1 cycle after the 3rd beat.
    - busy falls with it.
- Octave and rest:
  - Stimulus: note=13.
  - Response: toggle period 512 cycles.
  - Stimulus: note=25.
  - Response: toggle period 256 cycles.
  - Stimulus: note=0 duration=2.
  - Response: tone_out stays 0 and note_done comes after 2 beats.
- Pause:
  - Stimulus: note=1 duration=4; drop play after 1 beat, hold 3 beats, then restore play.
  - Response:
    - tone_out=0 while paused.
    - Paused beats are not counted.
    - note_done comes only after 3 further beats.
- Back-to-back and zero length:
  - Stimulus: assert new_note (duration=2) in the note_done cycle.
  - Response: accepted, busy=1 the next cycle.
  - Stimulus: duration=0.
  - Response: note_done the next cycle and busy never rises.
- Ignore during PLAY:
  - Stimulus: new_note with note=5 mid-note.
  - Response: tone period unchanged; note_done timing set by the original duration.
